// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline sequencer.
// ctrl_t bundles every stage enable/flush so each pipeline action is one constant.
package pipe_pkg;

  localparam int unsigned REG_W_DEF   = 5;
  localparam int unsigned MUL_LAT_DEF = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_bubble;
    logic exmem_en;
    logic exmem_bubble;
    logic memwb_bubble;
  } ctrl_t;

  // Whole pipe held with NOPs in every stage; also the reset control word
  localparam ctrl_t CTRL_NOP = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1,
                                 idex_en: 1'b0, idex_bubble: 1'b1, exmem_en: 1'b0,
                                 exmem_bubble: 1'b1, memwb_bubble: 1'b1};

  localparam ctrl_t CTRL_RUN = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                 idex_en: 1'b1, idex_bubble: 1'b0, exmem_en: 1'b1,
                                 exmem_bubble: 1'b0, memwb_bubble: 1'b0};

  localparam ctrl_t CTRL_MEM = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                 idex_en: 1'b0, idex_bubble: 1'b0, exmem_en: 1'b0,
                                 exmem_bubble: 1'b0, memwb_bubble: 1'b1};

  localparam ctrl_t CTRL_MUL = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                 idex_en: 1'b0, idex_bubble: 1'b0, exmem_en: 1'b1,
                                 exmem_bubble: 1'b1, memwb_bubble: 1'b0};

  localparam ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
                                    idex_en: 1'b1, idex_bubble: 1'b1, exmem_en: 1'b1,
                                    exmem_bubble: 1'b0, memwb_bubble: 1'b0};

  localparam ctrl_t CTRL_LOAD_USE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                      idex_en: 1'b1, idex_bubble: 1'b1, exmem_en: 1'b1,
                                      exmem_bubble: 1'b0, memwb_bubble: 1'b0};

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: the load in EX writes a register the ID instruction reads.
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_mem_read,
  output logic             load_use
);

  // Register 0 is hard-wired zero, so a load targeting it never creates a dependency
  always_comb begin
    load_use = ex_mem_read && (ex_rt != '0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stage enables/flushes for load-use, branch redirect, multiply hold
// and data-memory wait states, plus a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned REG_W   = REG_W_DEF,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_mem_read,
  input  logic             ex_mul_start,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             exmem_bubble,
  output logic             memwb_bubble,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned CW = $clog2(MUL_LAT);

  state_t        state, state_nx, eff;
  logic [CW-1:0] mul_cnt, mul_cnt_nx;
  ctrl_t         ctrl;
  logic          load_use;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_rt       (ex_rt),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  always_comb begin
    ctrl       = CTRL_RUN;
    state_nx   = state;
    mul_cnt_nx = mul_cnt;
    eff        = state;
    // Leaving MEM_WAIT acts in the same cycle as the state being resumed,
    // so a memory wait adds exactly its busy cycles to a multiply hold.
    if (state == MEM_WAIT && !mem_busy) begin
      eff = (mul_cnt != '0) ? MUL_WAIT : RUN;
    end
    if (!rst_n) begin
      ctrl     = CTRL_NOP;
      state_nx = RUN;
    end else if (mem_busy) begin
      ctrl     = CTRL_MEM;
      state_nx = MEM_WAIT;
    end else if (eff == MUL_WAIT) begin
      // The mul_cnt==0 cycle is still held; enables return on the following RUN cycle
      ctrl = CTRL_MUL;
      if (mul_cnt == '0) begin
        state_nx = RUN;
      end else begin
        mul_cnt_nx = mul_cnt - CW'(1);
        state_nx   = MUL_WAIT;
      end
    end else if (ex_mul_start) begin
      ctrl       = CTRL_MUL;
      mul_cnt_nx = CW'(MUL_LAT - 2);
      state_nx   = MUL_WAIT;
    end else if (branch_taken) begin
      ctrl     = CTRL_BRANCH;
      state_nx = RUN;
    end else if (load_use) begin
      ctrl     = CTRL_LOAD_USE;
      state_nx = RUN;
    end else begin
      state_nx = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      mul_cnt      <= '0;
      stall_cycles <= '0;
    end else begin
      state   <= state_nx;
      mul_cnt <= mul_cnt_nx;
      if (!ctrl.pc_en && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign ifid_en      = ctrl.ifid_en;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_en      = ctrl.idex_en;
  assign idex_bubble  = ctrl.idex_bubble;
  assign exmem_en     = ctrl.exmem_en;
  assign exmem_bubble = ctrl.exmem_bubble;
  assign memwb_bubble = ctrl.memwb_bubble;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (MUL_LAT=4, CNT_W=4 to reach saturation).
module tb_pipe_hazard_ctrl;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, exmem_bubble, memwb_bubble}
  localparam logic [7:0] C_RUN = 8'b1101_0100;
  localparam logic [7:0] C_NOP = 8'b0010_1011;
  localparam logic [7:0] C_MEM = 8'b0000_0001;
  localparam logic [7:0] C_MUL = 8'b0000_0110;
  localparam logic [7:0] C_BR  = 8'b1111_1100;
  localparam logic [7:0] C_LU  = 8'b0001_1100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0, ex_mul_start = 1'b0;
  logic       branch_taken = 1'b0, mem_busy = 1'b0;
  logic       pc_en, ifid_en, ifid_flush, idex_en, idex_bubble;
  logic       exmem_en, exmem_bubble, memwb_bubble;
  logic [3:0] stall_cycles;

  typedef struct {
    string      nm;
    logic [7:0] c;
    logic [3:0] s;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MUL_LAT(4), .REG_W(5), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_rt        (ex_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_mul_start (ex_mul_start),
    .branch_taken (branch_taken),
    .mem_busy     (mem_busy),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_en      (idex_en),
    .idex_bubble  (idex_bubble),
    .exmem_en     (exmem_en),
    .exmem_bubble (exmem_bubble),
    .memwb_bubble (memwb_bubble),
    .stall_cycles (stall_cycles)
  );

  task automatic cyc(input string nm, input logic r, input logic busy, input logic mul,
                     input logic br, input logic mrd, input logic [4:0] ert,
                     input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                     input logic [7:0] ec, input logic [3:0] es);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n        = r;
    mem_busy     = busy;
    ex_mul_start = mul;
    branch_taken = br;
    ex_mem_read  = mrd;
    ex_rt        = ert;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = urt;
    e.nm = nm;
    e.c  = ec;
    e.s  = es;
    sb.push_back(e);
  endtask

  task automatic idle(input string nm, input logic [7:0] ec, input logic [3:0] es);
    cyc(nm, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, ec, es);
  endtask

  // Monitor: outputs are Mealy, so compare mid-cycle on the falling edge
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e   = sb.pop_front();
        act = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
               exmem_en, exmem_bubble, memwb_bubble};
        n_chk++;
        if (act !== e.c) begin
          n_fail++;
          $display("FAIL %s ctrl: got %b expected %b", e.nm, act, e.c);
        end
        n_chk++;
        if (stall_cycles !== e.s) begin
          n_fail++;
          $display("FAIL %s stall_cycles: got %0d expected %0d", e.nm, stall_cycles, e.s);
        end
      end
    end
  end

  initial begin
    // T1: reset, run, then reset again in the middle of a multiply hold
    cyc("rst_hold0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_NOP, 4'd0);
    cyc("rst_hold1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_NOP, 4'd0);
    idle("rst_release", C_RUN, 4'd0);
    cyc("mem_busy1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_MEM, 4'd0);
    idle("mem_exit_run", C_RUN, 4'd1);
    cyc("mul_pre_rst", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_MUL, 4'd1);
    idle("mulwait_pre_rst", C_MUL, 4'd2);
    cyc("rst_mid_mul", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_NOP, 4'd0);
    idle("rst_mid_release", C_RUN, 4'd0);
    idle("run_after_rst", C_RUN, 4'd0);
    // T2: load-use on rs, ex_rt=0 exemption, rt match gated by id_uses_rt
    cyc("lu_rs", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, C_LU, 4'd0);
    idle("lu_rs_after", C_RUN, 4'd1);
    cyc("lu_r0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, C_RUN, 4'd1);
    cyc("lu_rt", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, C_LU, 4'd1);
    cyc("lu_rt_unused", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, C_RUN, 4'd2);
    cyc("lu_noload", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0, C_RUN, 4'd2);
    // T3: branch beats load-use; no stall counted
    cyc("br_over_lu", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, C_BR, 4'd2);
    idle("br_after", C_RUN, 4'd2);
    // T4: multiply holds for 4 cycles; branch during MUL_WAIT is ignored
    cyc("mul_start", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_MUL, 4'd2);
    idle("mul_wait2", C_MUL, 4'd3);
    cyc("mul_wait1_br", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_MUL, 4'd4);
    idle("mul_wait0", C_MUL, 4'd5);
    idle("mul_done", C_RUN, 4'd6);
    // T5: memory wait inside a multiply preserves the count; 7 stall cycles in total
    cyc("t5_mul_start", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_MUL, 4'd6);
    idle("t5_mul_wait2", C_MUL, 4'd7);
    cyc("t5_busy0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_MEM, 4'd8);
    cyc("t5_busy1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_MEM, 4'd9);
    cyc("t5_busy2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_MEM, 4'd10);
    idle("t5_resume1", C_MUL, 4'd11);
    idle("t5_resume0", C_MUL, 4'd12);
    idle("t5_done", C_RUN, 4'd13);
    // Priority: mem_busy over multiply and branch; multiply over branch
    cyc("pri_busy", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_MEM, 4'd13);
    idle("pri_busy_exit", C_RUN, 4'd14);
    cyc("pri_mul_br", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_MUL, 4'd14);
    idle("pri_mul_w2", C_MUL, 4'd15);
    idle("pri_mul_w1", C_MUL, 4'd15);
    idle("pri_mul_w0", C_MUL, 4'd15);
    idle("pri_mul_done", C_RUN, 4'd15);
    // T6: 20 frozen cycles saturate a 4-bit counter at 15
    cyc("t6_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_NOP, 4'd0);
    idle("t6_release", C_RUN, 4'd0);
    for (int i = 0; i < 20; i++) begin
      cyc("t6_sat", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, C_MEM,
          (i > 15) ? 4'd15 : 4'(i));
    end
    idle("t6_exit", C_RUN, 4'd15);
    idle("t6_hold", C_RUN, 4'd15);

    repeat (3) @(posedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
